// File: rtl/background_engine.sv
// Registered VGA background generator: frame-stepped animation time base,
// writable palette and a mode register that only switches at frame boundaries.
module background_engine #(
  parameter int HTOTAL     = 800,
  parameter int VTOTAL     = 525,
  parameter int COLOR_BITS = 6,
  parameter int PAL_DEPTH  = 4,
  parameter int SPEED_BITS = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_start,
  input  logic signed [$clog2(HTOTAL):0] counter_h,
  input  logic signed [$clog2(VTOTAL):0] counter_v,
  input  logic [2:0]                     mode_req,
  input  logic [SPEED_BITS-1:0]          speed,
  input  logic                           direction,
  input  logic                           pause,
  input  logic                           pal_we,
  input  logic [$clog2(PAL_DEPTH)-1:0]   pal_addr,
  input  logic [COLOR_BITS-1:0]          pal_data,
  output logic [COLOR_BITS-1:0]          color_out,
  output logic [2:0]                     mode_active,
  output logic [7:0]                     cur_time
);

  localparam int L = $clog2(PAL_DEPTH);

  logic [COLOR_BITS-1:0] pal_q [PAL_DEPTH];
  logic [COLOR_BITS-1:0] pal_d [PAL_DEPTH];
  logic [COLOR_BITS-1:0] color_q, color_d;
  logic [2:0]            mode_q, mode_d;
  logic [7:0]            time_q, time_d;
  logic [SPEED_BITS-1:0] presc_q, presc_d;

  logic [11:0]           h_ext_s, v_ext_s, t_ext_s;
  logic [11:0]           sum_hvt_s, sum_vt_s, sum_ht_s;
  logic [5:0]            xor6_s;
  logic [COLOR_BITS+5:0] xor_wide_s;
  logic                  unused_bits_s;

  // Pixel index arithmetic: 12-bit two's complement sums, counters sign-extended, time zero-extended
  always_comb begin
    h_ext_s    = 12'(counter_h);
    v_ext_s    = 12'(counter_v);
    t_ext_s    = {4'd0, time_q};
    sum_hvt_s  = h_ext_s + v_ext_s + t_ext_s;
    sum_vt_s   = v_ext_s + t_ext_s;
    sum_ht_s   = h_ext_s + t_ext_s;
    xor6_s     = (h_ext_s[7:2] ^ v_ext_s[7:2]) + time_q[7:2];
    xor_wide_s = {{COLOR_BITS{1'b0}}, xor6_s};
  end

  // Only slices of the sums select colours; the remaining bits are intentionally dropped
  assign unused_bits_s = ^{sum_hvt_s, sum_vt_s, sum_ht_s, v_ext_s, xor_wide_s};

  // Colour selection from the state as it stands this cycle
  always_comb begin
    color_d = pal_q[0];
    case (mode_q)
      3'd0:    color_d = pal_q[0];
      3'd1:    color_d = xor_wide_s[COLOR_BITS-1:0];
      3'd2:    color_d = pal_q[sum_hvt_s[6+L-1:6]];
      3'd3:    color_d = pal_q[sum_vt_s[5+L-1:5]];
      3'd4:    color_d = pal_q[L'(sum_ht_s[5] ^ v_ext_s[5])];
      default: color_d = pal_q[0];
    endcase
  end

  // Time base, mode latch and palette write next-state
  always_comb begin
    mode_d  = mode_q;
    time_d  = time_q;
    presc_d = presc_q;
    pal_d   = pal_q;
    if (frame_start) begin
      mode_d = mode_req;
      if (!pause) begin
        // >= lets a lowered speed fire on the very next frame
        if (presc_q >= speed) begin
          presc_d = '0;
          if (direction) begin
            time_d = time_q - 8'd1;
          end else begin
            time_d = time_q + 8'd1;
          end
        end else begin
          presc_d = presc_q + SPEED_BITS'(1);
        end
      end else begin
        presc_d = presc_q;
      end
    end else begin
      mode_d = mode_q;
    end
    if (pal_we) begin
      pal_d[pal_addr] = pal_data;
    end else begin
      pal_d = pal_q;
    end
  end

  // State registers with synchronous reset; palette returns to identity defaults
  always_ff @(posedge clk) begin
    if (reset) begin
      color_q <= '0;
      mode_q  <= 3'd0;
      time_q  <= 8'd0;
      presc_q <= '0;
      for (int i = 0; i < PAL_DEPTH; i++) begin
        pal_q[i] <= COLOR_BITS'(i);
      end
    end else begin
      color_q <= color_d;
      mode_q  <= mode_d;
      time_q  <= time_d;
      presc_q <= presc_d;
      pal_q   <= pal_d;
    end
  end

  assign color_out   = color_q;
  assign mode_active = mode_q;
  assign cur_time    = time_q;

endmodule

// File: tb/tb_background_engine.sv
// Directed plus randomized bench for background_engine against a behavioural model.
module tb_background_engine;

  localparam int HTOTAL = 800;
  localparam int VTOTAL = 525;
  localparam int CB     = 6;
  localparam int PD     = 4;
  localparam int SB     = 3;

  logic                           clk = 1'b0;
  logic                           reset;
  logic                           frame_start;
  logic signed [$clog2(HTOTAL):0] counter_h;
  logic signed [$clog2(VTOTAL):0] counter_v;
  logic [2:0]                     mode_req;
  logic [SB-1:0]                  speed;
  logic                           direction;
  logic                           pause;
  logic                           pal_we;
  logic [$clog2(PD)-1:0]          pal_addr;
  logic [CB-1:0]                  pal_data;
  logic [CB-1:0]                  color_out;
  logic [2:0]                     mode_active;
  logic [7:0]                     cur_time;

  int n_eval = 0;
  int n_fail = 0;
  int m_pal [PD];
  int m_mode, m_time, m_presc;

  always #5 clk = ~clk;

  background_engine #(
    .HTOTAL(HTOTAL), .VTOTAL(VTOTAL), .COLOR_BITS(CB), .PAL_DEPTH(PD), .SPEED_BITS(SB)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .counter_h(counter_h), .counter_v(counter_v), .mode_req(mode_req),
    .speed(speed), .direction(direction), .pause(pause),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .color_out(color_out), .mode_active(mode_active), .cur_time(cur_time)
  );

  function automatic int ref_color(int h, int v, int mode, int t);
    case (mode)
      1:       return ((((h >>> 2) & 63) ^ ((v >>> 2) & 63)) + (t >>> 2)) & 63;
      2:       return m_pal[((h + v + t) >>> 6) & (PD - 1)];
      3:       return m_pal[((v + t) >>> 5) & (PD - 1)];
      4:       return m_pal[(((h + t) >>> 5) & 1) ^ ((v >>> 5) & 1)];
      default: return m_pal[0];
    endcase
  endfunction

  task automatic check(string tag, int obs, int exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_time = 0; m_presc = 0;
    for (int i = 0; i < PD; i++) m_pal[i] = i;
  endtask

  // One clock: predict from pre-edge state, advance model, then compare
  task automatic cycle();
    int exp_c;
    exp_c = reset ? 0 : ref_color(int'(counter_h), int'(counter_v), m_mode, m_time);
    if (reset) begin
      model_reset();
    end else begin
      if (pal_we) m_pal[int'(pal_addr)] = int'(pal_data);
      if (frame_start) begin
        m_mode = int'(mode_req);
        if (!pause) begin
          if (m_presc >= int'(speed)) begin
            m_presc = 0;
            m_time  = direction ? (m_time + 255) % 256 : (m_time + 1) % 256;
          end else begin
            m_presc = m_presc + 1;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("color", int'(color_out), exp_c);
    check("mode", int'(mode_active), m_mode);
    check("time", int'(cur_time), m_time);
  endtask

  task automatic pulses(int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1; cycle();
      frame_start = 1'b0; cycle();
    end
  endtask

  task automatic randomize_inputs();
    frame_start = 1'($urandom_range(0, 1));
    counter_h   = 11'($urandom_range(0, 2047));
    counter_v   = 11'($urandom_range(0, 2047));
    mode_req    = 3'($urandom_range(0, 7));
    speed       = 3'($urandom_range(0, 7));
    direction   = 1'($urandom_range(0, 1));
    pause       = 1'($urandom_range(0, 1));
    pal_we      = 1'($urandom_range(0, 1));
    pal_addr    = 2'($urandom_range(0, 3));
    pal_data    = 6'($urandom_range(0, 63));
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    randomize_inputs();
    @(negedge clk);

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      cycle();
    end
    check("rst_color_lit", int'(color_out), 0);
    reset = 1'b0; frame_start = 1'b0; pal_we = 1'b0; pause = 1'b0;
    direction = 1'b0; speed = 3'd0; mode_req = 3'd0;
    counter_h = 11'sd5; counter_v = 11'sd7;
    cycle();
    check("mode0_pal0_lit", int'(color_out), 0);

    // XOR mode at t=8, h=12, v=20
    mode_req = 3'd1; counter_h = 11'sd12; counter_v = 11'sd20;
    pulses(8);
    check("xor_time_lit", int'(cur_time), 8);
    check("xor_color_lit", int'(color_out), 8);

    // Diagonal mode with palette write, t back to 0
    direction = 1'b1; mode_req = 3'd2;
    pulses(8);
    counter_h = 11'sd100; counter_v = 11'sd30;
    pal_we = 1'b1; pal_addr = 2'd2; pal_data = 6'h2A;
    cycle();
    pal_we = 1'b0;
    cycle();
    check("diag_lit", int'(color_out), 42);
    pal_we = 1'b1; pal_data = 6'h15;
    cycle();
    check("diag_old_lit", int'(color_out), 42);
    pal_we = 1'b0;
    cycle();
    check("diag_new_lit", int'(color_out), 21);

    // Speed divider and pause
    direction = 1'b0; speed = 3'd2;
    pulses(9);
    check("speed_lit", int'(cur_time), 3);
    pause = 1'b1;
    pulses(5);
    check("pause_lit", int'(cur_time), 3);
    pause = 1'b0;
    pulses(1);
    check("presc_lit", int'(cur_time), 3);
    speed = 3'd0;
    pulses(1);
    check("lower_speed_lit", int'(cur_time), 4);

    // Wrap both directions
    direction = 1'b1;
    pulses(4);
    check("down_zero_lit", int'(cur_time), 0);
    pulses(1);
    check("wrap_down_lit", int'(cur_time), 255);
    direction = 1'b0;
    pulses(1);
    check("wrap_up_lit", int'(cur_time), 0);

    // Mode deferral and reserved modes
    mode_req = 3'd1;
    pulses(1);
    mode_req = 3'd2;
    repeat (5) cycle();
    check("defer_lit", int'(mode_active), 1);
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    check("defer_switch_lit", int'(mode_active), 2);
    pal_we = 1'b1; pal_addr = 2'd0; pal_data = 6'h33;
    cycle();
    pal_we = 1'b0;
    for (int m = 5; m < 8; m++) begin
      mode_req = 3'(m);
      pulses(1);
      check("reserved_lit", int'(color_out), 51);
    end

    // Reset mid-frame restores palette defaults
    reset = 1'b1; frame_start = 1'b1; pal_we = 1'b1;
    cycle();
    reset = 1'b0; frame_start = 1'b0; pal_we = 1'b0;
    mode_req = 3'd3;
    pulses(1);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      frame_start = ($urandom_range(0, 7) == 0);
      pal_we      = ($urandom_range(0, 3) == 0);
      pause       = ($urandom_range(0, 3) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
